// File: rtl/multicycle_control_if.sv
// Multi-cycle control interface.
// Groups the instruction-register opcode, the memory ready handshake and every
// datapath control line into one bundle.
//   master : the control FSM. It takes op and mem_ready and drives the controls.
//   slave  : the datapath/memory side, or a testbench standing in for it.
interface multicycle_control_if #(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 2
);
  logic [OP_W-1:0]    op;
  logic               mem_ready;
  logic               pc_write;
  logic               pc_write_cond;
  logic               iord;
  logic               mem_read;
  logic               mem_write;
  logic               ir_write;
  logic               mem_to_reg;
  logic               reg_dst;
  logic               reg_write;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [ALUOP_W-1:0] alu_op;
  logic [1:0]         pc_src;
  logic               illegal_op;
  logic               instr_done;

  modport master (
    input  op, mem_ready,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_src, illegal_op, instr_done
  );

  modport slave (
    output op, mem_ready,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_src, illegal_op, instr_done
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control FSM.
// Each instruction is sequenced over 3 to 5 states. Memory states stall on the
// mem_ready handshake. The block pulses instr_done in the last state of every
// instruction and pulses illegal_op when DECODE sees an undefined opcode.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous, active-high reset. While it is high, every output is at
//         its default value.
//   bus : multicycle_control_if.master. The inputs are op and mem_ready; the
//         outputs are all the datapath mux selects and enables.
//
// state   | meaning
// --------+--------------------------------------------------------------
// FETCH   | read instruction at PC; on ready load IR and PC <= PC+4
// DECODE  | precompute branch target, dispatch on op
// MEMADR  | ALUOut <= rs + signext(imm) for LW/SW
// MEMRD   | read data memory at ALUOut, wait for ready
// MEMWB   | rt <= MDR
// MEMWR   | write data memory at ALUOut, wait for ready
// EXEC    | R-type ALU operation (funct-controlled)
// ALUWB   | rd <= ALUOut
// BRANCH  | compare rs/rt, conditional PC <= branch target
// ADDIEX  | rs + signext(imm)
// ADDIWB  | rt <= ALUOut
// JUMP    | PC <= jump target
module multicycle_control #(
  parameter int OP_W     = 6,
  parameter int ALUOP_W  = 2,
  parameter bit MEM_WAIT = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  multicycle_control_if.master bus
);

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'h00);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'h02);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'h04);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'h08);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'h23);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'h2B);

  localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(2'b00);
  localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(2'b01);
  localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(2'b10);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  state_t state, state_nxt;
  // op is only valid during DECODE. This flag remembers LW vs SW so that
  // MEMADR can choose its successor.
  logic   is_store;
  logic   ready_ok;

  // With MEM_WAIT=0 every memory state completes in one cycle.
  assign ready_ok = bus.mem_ready || !MEM_WAIT;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      is_store <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE) is_store <= (bus.op == OP_SW);
    end
  end

  always_comb begin
    state_nxt         = S_FETCH;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.iord          = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.alu_op        = ALU_ADD;
    bus.pc_src        = 2'b00;
    bus.illegal_op    = 1'b0;
    bus.instr_done    = 1'b0;

    // Reset holds every output at its default value. It also abandons the
    // in-flight instruction.
    if (!rst) begin
      case (state)
        S_FETCH: begin
          bus.mem_read  = 1'b1;
          bus.alu_src_b = 2'b01;
          if (ready_ok) begin
            bus.ir_write = 1'b1;
            bus.pc_write = 1'b1;
            state_nxt    = S_DECODE;
          end else begin
            state_nxt = S_FETCH;
          end
        end
        S_DECODE: begin
          bus.alu_src_b = 2'b11;
          case (bus.op)
            OP_LW, OP_SW: state_nxt = S_MEMADR;
            OP_RTYPE:     state_nxt = S_EXEC;
            OP_BEQ:       state_nxt = S_BRANCH;
            OP_ADDI:      state_nxt = S_ADDIEX;
            OP_J:         state_nxt = S_JUMP;
            default: begin
              // PC has already advanced in FETCH, so the bad word is skipped.
              bus.illegal_op = 1'b1;
              state_nxt      = S_FETCH;
            end
          endcase
        end
        S_MEMADR: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'b10;
          state_nxt     = is_store ? S_MEMWR : S_MEMRD;
        end
        S_MEMRD: begin
          bus.mem_read = 1'b1;
          bus.iord     = 1'b1;
          state_nxt    = ready_ok ? S_MEMWB : S_MEMRD;
        end
        S_MEMWB: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = 1'b1;
          bus.instr_done = 1'b1;
          state_nxt      = S_FETCH;
        end
        S_MEMWR: begin
          bus.mem_write = 1'b1;
          bus.iord      = 1'b1;
          if (ready_ok) begin
            bus.instr_done = 1'b1;
            state_nxt      = S_FETCH;
          end else begin
            state_nxt = S_MEMWR;
          end
        end
        S_EXEC: begin
          bus.alu_src_a = 1'b1;
          bus.alu_op    = ALU_FUNCT;
          state_nxt     = S_ALUWB;
        end
        S_ALUWB: begin
          bus.reg_write  = 1'b1;
          bus.reg_dst    = 1'b1;
          bus.instr_done = 1'b1;
          state_nxt      = S_FETCH;
        end
        S_BRANCH: begin
          bus.alu_src_a     = 1'b1;
          bus.alu_op        = ALU_SUB;
          bus.pc_write_cond = 1'b1;
          bus.pc_src        = 2'b01;
          bus.instr_done    = 1'b1;
          state_nxt         = S_FETCH;
        end
        S_ADDIEX: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'b10;
          state_nxt     = S_ADDIWB;
        end
        S_ADDIWB: begin
          bus.reg_write  = 1'b1;
          bus.instr_done = 1'b1;
          state_nxt      = S_FETCH;
        end
        S_JUMP: begin
          bus.pc_write   = 1'b1;
          bus.pc_src     = 2'b10;
          bus.instr_done = 1'b1;
          state_nxt      = S_FETCH;
        end
        default: state_nxt = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_control_if #(.OP_W(6), .ALUOP_W(2)) bus ();

  multicycle_control #(.OP_W(6), .ALUOP_W(2), .MEM_WAIT(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Control vector layout:
  // {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
  //  reg_dst, reg_write, alu_src_a, alu_src_b[1:0], alu_op[1:0], pc_src[1:0],
  //  illegal_op, instr_done}
  typedef logic [17:0] cv_t;

  function automatic cv_t mk(input logic pw, pwc, iord, mr, mw, irw, m2r, rdst,
                             rw, asa, input logic [1:0] asb, aop, psrc,
                             input logic ill, done);
    return {pw, pwc, iord, mr, mw, irw, m2r, rdst, rw, asa, asb, aop, psrc, ill, done};
  endfunction

  // Expected vectors, one per state/condition, written down from the state descriptions.
  cv_t V_IDLE, V_F_WAIT, V_F_RDY, V_D, V_D_ILL, V_MA, V_MR, V_MWB, V_MW_WAIT,
       V_MW_RDY, V_EX, V_AWB, V_BR, V_AX, V_AXWB, V_J;

  initial begin
    V_IDLE    = '0;
    V_F_WAIT  = mk(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0);
    V_F_RDY   = mk(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0,0);
    V_D       = mk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0);
    V_D_ILL   = mk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,1,0);
    V_MA      = mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0);
    V_MR      = mk(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0);
    V_MWB     = mk(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0,1);
    V_MW_WAIT = mk(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0);
    V_MW_RDY  = mk(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,1);
    V_EX      = mk(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0,0);
    V_AWB     = mk(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0,1);
    V_BR      = mk(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0,1);
    V_AX      = mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0);
    V_AXWB    = mk(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0,1);
    V_J       = mk(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,0,1);
  end

  typedef struct {
    cv_t   exp;
    string name;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  cv_t act;
  assign act = {bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_read,
                bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst,
                bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                bus.pc_src, bus.illegal_op, bus.instr_done};

  // Monitor: compares the cycle's outputs on the falling edge, away from the
  // active edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (act !== e.exp) begin
        failures++;
        $display("FAIL %s: got %b expected %b", e.name, act, e.exp);
      end
    end
  end

  // Drives one cycle of inputs and queues the outputs expected in that cycle.
  task automatic step(input logic r, input logic [5:0] o, input logic rdy,
                      input cv_t e, input string name);
    exp_t x;
    @(posedge clk);
    #1;
    rst           = r;
    bus.op        = o;
    bus.mem_ready = rdy;
    x.exp  = e;
    x.name = name;
    q.push_back(x);
  endtask

  initial begin
    bus.op        = 6'h00;
    bus.mem_ready = 1'b0;
    rst           = 1'b1;

    step(1, 6'h00, 1, V_IDLE,    "rst_c1");
    step(1, 6'h00, 1, V_IDLE,    "rst_c2");

    // LW with immediate ready: F, D, MA, MR, WB.
    step(0, 6'h23, 1, V_F_RDY,   "lw_fetch");
    step(0, 6'h23, 1, V_D,       "lw_decode");
    step(0, 6'h23, 1, V_MA,      "lw_memadr");
    step(0, 6'h23, 1, V_MR,      "lw_memrd");
    step(0, 6'h23, 1, V_MWB,     "lw_memwb");

    // SW stalled 3 cycles in MEMWR.
    step(0, 6'h2B, 1, V_F_RDY,   "sw_fetch");
    step(0, 6'h2B, 1, V_D,       "sw_decode");
    step(0, 6'h2B, 1, V_MA,      "sw_memadr");
    step(0, 6'h2B, 0, V_MW_WAIT, "sw_wait1");
    step(0, 6'h2B, 0, V_MW_WAIT, "sw_wait2");
    step(0, 6'h2B, 0, V_MW_WAIT, "sw_wait3");
    step(0, 6'h2B, 1, V_MW_RDY,  "sw_done");

    // Fetch stall, then illegal opcode.
    step(0, 6'h3F, 0, V_F_WAIT,  "ill_fetch_wait");
    step(0, 6'h3F, 1, V_F_RDY,   "ill_fetch");
    step(0, 6'h3F, 1, V_D_ILL,   "ill_decode");

    // BEQ then J back to back (cycles 3 and 6).
    step(0, 6'h04, 1, V_F_RDY,   "beq_fetch");
    step(0, 6'h04, 1, V_D,       "beq_decode");
    step(0, 6'h04, 1, V_BR,      "beq_branch");
    step(0, 6'h02, 1, V_F_RDY,   "j_fetch");
    step(0, 6'h02, 1, V_D,       "j_decode");
    step(0, 6'h02, 1, V_J,       "j_jump");

    // RTYPE.
    step(0, 6'h00, 1, V_F_RDY,   "r_fetch");
    step(0, 6'h00, 1, V_D,       "r_decode");
    step(0, 6'h00, 1, V_EX,      "r_exec");
    step(0, 6'h00, 1, V_AWB,     "r_aluwb");

    // ADDI.
    step(0, 6'h08, 1, V_F_RDY,   "addi_fetch");
    step(0, 6'h08, 1, V_D,       "addi_decode");
    step(0, 6'h08, 1, V_AX,      "addi_ex");
    step(0, 6'h08, 1, V_AXWB,    "addi_wb");

    // LW aborted by reset while in MEMRD.
    step(0, 6'h23, 1, V_F_RDY,   "lwa_fetch");
    step(0, 6'h23, 1, V_D,       "lwa_decode");
    step(0, 6'h23, 1, V_MA,      "lwa_memadr");
    step(0, 6'h23, 0, V_MR,      "lwa_memrd_wait");
    step(1, 6'h23, 1, V_IDLE,    "lwa_rst");
    step(0, 6'h23, 0, V_F_WAIT,  "lwa_refetch");
    step(0, 6'h23, 1, V_F_RDY,   "lwa_refetch_rdy");
    step(0, 6'h23, 1, V_D,       "lwa_redecode");

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain: got %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
